lowclk_ctrl: RTL and testbench
==============================

Name: lowclk_ctrl

Overview:
Sequencing controller for the shared low-rate clock divider.
- Owns the divider's period and synchronous reset inputs, and watches the divider output.
- Runs the divider free-running or for a programmed burst of N output rising edges, then stops it.
- Accepts period/count reconfiguration over a valid/ready port. Mid-run period changes take effect only at a divider rising edge, so there are no runt phases.

Parameters:
PW, 32, width of period values (matches divider period input)
CW, 16, width of burst count and edge counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cfg_valid  input  1  configuration request
cfg_ready  output  1  configuration accept
cfg_period  input  PW  requested divider period (0 clamped to 1)
cfg_count  input  CW  burst length in divider rising edges; 0 = free-run
start  input  1  one-cycle start request
stop  input  1  one-cycle abort request
lclk_in  input  1  divider output, same clock domain
div_period  output  PW  period driven to divider
div_reset  output  1  active-high synchronous reset driven to divider
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse when a burst completes
edge_cnt  output  CW  rising edges counted in current run

Behaviour:
Reset (reset=0, async):
- State = IDLE; div_reset = 1; div_period = 1; active count = 0.
- busy = 0; done = 0; edge_cnt = 0; cfg_ready = 1; pending flag clear; lclk_d = 0.

Edge detect:
- lclk_d registers lclk_in each cycle.
- rise = lclk_in & ~lclk_d, valid only in RUN.

Configuration handshake (accept = cfg_valid & cfg_ready):
- cfg_ready = 1 in IDLE, and in RUN when no pending config; 0 in LOAD and when a config is pending.
- IDLE accept: clamped period and count are written to the active registers. div_period updates on the next edge.
- RUN accept: values are stored in the pending registers and the pending flag is set. They are applied on the next cycle with rise: div_period and active count update, the pending flag clears, and cfg_ready returns to 1 the following cycle.
- Period 0 from cfg_period is always stored as 1.

FSM:
- IDLE: div_reset = 1.
  - start & ~stop → LOAD. A cfg accepted in the same cycle is applied first, so LOAD uses the new values.
  - start & stop in the same cycle → stay IDLE.
- LOAD (exactly 1 cycle): div_reset = 1, busy = 1, edge_cnt cleared to 0 → RUN.
- RUN: div_reset = 0, busy = 1.
  - On rise: edge_cnt += 1, wrapping at 2^CW in free-run.
  - If active count ≠ 0 and edge_cnt+1 == active count on a rise: next state IDLE, done = 1 for one cycle, div_reset = 1.
  - stop → IDLE next cycle, div_reset = 1, done stays 0. A pending config is discarded and cfg_ready = 1 in IDLE.
  - stop and final rise in the same cycle: stop wins, no done.
  - start in RUN or LOAD is ignored.
  - Pending config and final rise in the same cycle: the burst completes and the pending values become active for the next run.

Timing:
- edge_cnt holds its value in IDLE until the next LOAD.
- First divider rising edge arrives period+1 cycles after div_reset deasserts.
- Latency from start to div_reset low is 2 cycles.
- Reset asserted mid-run forces IDLE immediately; no done pulse.

Test Plan:
1. Reset, cfg period=3 count=4 in IDLE, start → cfg_ready=1, busy rises 1 cycle after start, div_reset low 2 cycles after start; 4 lclk_in rises counted; done pulses once the cycle after the 4th rise; edge_cnt=4 held; div_reset=1.
2. cfg period=2 count=0, start, run 20 rises, stop → edge_cnt=20, no done, busy=0 next cycle, div_reset=1.
3. Free-run period=5, mid-run cfg period=1 → cfg_ready drops after accept; div_period stays 5 until the next rise, then becomes 1; cfg_ready=1 again; no high or low phase shorter than 2 cycles observed on lclk_in.
4. cfg_period=0 in IDLE → div_period reads 1.
5. Simultaneous events:
   - start & stop in IDLE → remains IDLE, busy=0.
   - stop on the cycle of the final burst rise → IDLE, done never asserts.
6. Async reset=0 mid-burst (count=10, 3 edges in) → busy=0, edge_cnt=0, div_reset=1, done=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/lowclk_ctrl.sv
// Sequencing controller for the shared low-rate clock divider: free-run or
// N-edge bursts, with period/count reconfiguration applied on divider rising edges.
module lowclk_ctrl #(
  parameter int PW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [PW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_count,
  input  logic          start,
  input  logic          stop,
  input  logic          lclk_in,
  output logic [PW-1:0] div_period,
  output logic          div_reset,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [PW-1:0] PERIOD_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

  // A zero period would stall the divider, so it is stored as one.
  function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == {PW{1'b0}}) begin
      r = PERIOD_ONE;
    end else begin
      r = p;
    end
    return r;
  endfunction

  state_t        state_r, state_s;
  logic          lclk_d_r;
  logic [PW-1:0] div_period_r, div_period_s;
  logic [CW-1:0] act_count_r, act_count_s;
  logic [PW-1:0] pend_period_r, pend_period_s;
  logic [CW-1:0] pend_count_r, pend_count_s;
  logic          pend_r, pend_s;
  logic [CW-1:0] edge_cnt_r, edge_cnt_s;
  logic          done_r, done_s;
  logic          busy_r, div_reset_r, cfg_ready_r;
  logic          accept_s, rise_s, final_s;
  logic [CW-1:0] edge_inc_s;

  // Next-state, configuration and counter logic.
  always_comb begin
    state_s       = state_r;
    div_period_s  = div_period_r;
    act_count_s   = act_count_r;
    pend_period_s = pend_period_r;
    pend_count_s  = pend_count_r;
    pend_s        = pend_r;
    edge_cnt_s    = edge_cnt_r;
    done_s        = 1'b0;
    accept_s      = cfg_valid & cfg_ready_r;
    rise_s        = lclk_in & ~lclk_d_r & (state_r == RUN);
    edge_inc_s    = edge_cnt_r + CNT_ONE;
    final_s       = rise_s & (act_count_r != CNT_ZERO) & (edge_inc_s == act_count_r);

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          div_period_s = clamp_period(cfg_period);
          act_count_s  = cfg_count;
        end else begin
          div_period_s = div_period_r;
        end
        if (start & ~stop) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        edge_cnt_s = CNT_ZERO;
        state_s    = RUN;
      end
      RUN: begin
        if (rise_s) begin
          edge_cnt_s = edge_inc_s;
        end else begin
          edge_cnt_s = edge_cnt_r;
        end
        if (stop) begin
          // Abort discards any pending configuration and never signals done.
          state_s = IDLE;
          pend_s  = 1'b0;
        end else begin
          if (accept_s) begin
            pend_period_s = clamp_period(cfg_period);
            pend_count_s  = cfg_count;
            pend_s        = 1'b1;
          end else if (pend_r & rise_s) begin
            div_period_s = pend_period_r;
            act_count_s  = pend_count_r;
            pend_s       = 1'b0;
          end else begin
            pend_s = pend_r;
          end
          if (final_s) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end
      end
      default: begin
        state_s = IDLE;
        pend_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; outputs are derived from next-state values
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      lclk_d_r      <= 1'b0;
      div_period_r  <= PERIOD_ONE;
      act_count_r   <= CNT_ZERO;
      pend_period_r <= PERIOD_ONE;
      pend_count_r  <= CNT_ZERO;
      pend_r        <= 1'b0;
      edge_cnt_r    <= CNT_ZERO;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      div_reset_r   <= 1'b1;
      cfg_ready_r   <= 1'b1;
    end else begin
      state_r       <= state_s;
      lclk_d_r      <= lclk_in;
      div_period_r  <= div_period_s;
      act_count_r   <= act_count_s;
      pend_period_r <= pend_period_s;
      pend_count_r  <= pend_count_s;
      pend_r        <= pend_s;
      edge_cnt_r    <= edge_cnt_s;
      done_r        <= done_s;
      busy_r        <= (state_s != IDLE);
      div_reset_r   <= (state_s != RUN);
      cfg_ready_r   <= (state_s == IDLE) | ((state_s == RUN) & ~pend_s);
    end
  end

  assign cfg_ready  = cfg_ready_r;
  assign div_period = div_period_r;
  assign div_reset  = div_reset_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign edge_cnt   = edge_cnt_r;

endmodule

// File: tb/tb_lowclk_ctrl.sv
// Directed bench for lowclk_ctrl with a behavioural divider driving lclk_in.
module tb_lowclk_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_period = 32'd0;
  logic [15:0] cfg_count = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        lclk = 1'b0;
  logic [31:0] div_period;
  logic        div_reset;
  logic        busy;
  logic        done;
  logic [15:0] edge_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  int done_seen = 0;
  bit rise_seen = 1'b0;
  bit prev_l = 1'b0;
  bit track_phase = 1'b0;
  bit had_edge = 1'b0;
  int run_len = 0;
  int min_phase = 1000;
  logic [31:0] dcnt = 32'd0;

  lowclk_ctrl #(.PW(32), .CW(16)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_count(cfg_count), .start(start), .stop(stop),
    .lclk_in(lclk), .div_period(div_period), .div_reset(div_reset),
    .busy(busy), .done(done), .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  // Divider: output toggles every period+1 clocks, held low while in reset.
  always @(posedge clk) begin
    if (div_reset) begin
      dcnt <= 32'd0;
      lclk <= 1'b0;
    end else if (dcnt >= div_period) begin
      dcnt <= 32'd0;
      lclk <= ~lclk;
    end else begin
      dcnt <= dcnt + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rise_seen = lclk & ~prev_l;
    if (rise_seen) rises++;
    if (done) done_seen++;
    if (lclk != prev_l) begin
      if (track_phase && had_edge && run_len < min_phase) min_phase = run_len;
      had_edge = track_phase;
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_l = lclk;
  endtask

  task automatic wait_rises(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rise_seen && rises == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic configure(input logic [31:0] p, input logic [15:0] c);
    cfg_valid = 1'b1; cfg_period = p; cfg_count = c;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, div_reset, cfg_ready} !== 4'b0011) begin
      errors++; $display("FAIL reset_flags got busy/done/div_reset/cfg_ready=%b want 0011", {busy, done, div_reset, cfg_ready});
    end
    checks++;
    if (div_period !== 32'd1 || edge_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_values got div_period=%0d edge_cnt=%0d want 1 0", div_period, edge_cnt);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    int r4 = -1;
    int dcyc = -1;
    int dn = 0;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL burst_cfg_ready got %b want 1", cfg_ready);
    end
    configure(32'd3, 16'd4);
    checks++;
    if (div_period !== 32'd3) begin
      errors++; $display("FAIL burst_period got %0d want 3", div_period);
    end
    rises = 0;
    do_start();
    checks++;
    if (busy !== 1'b1 || div_reset !== 1'b1) begin
      errors++; $display("FAIL burst_load got busy=%b div_reset=%b want 1 1", busy, div_reset);
    end
    tick();
    checks++;
    if (div_reset !== 1'b0) begin
      errors++; $display("FAIL burst_div_reset_low got %b want 0", div_reset);
    end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rise_seen && rises == 4) r4 = cyc;
      if (done) begin dn++; dcyc = cyc; end
      if (!busy) break;
    end
    checks++;
    if (dn !== 1 || dcyc !== r4 + 1 || r4 < 0) begin
      errors++; $display("FAIL burst_done got pulses=%0d done_cyc=%0d rise4_cyc=%0d want 1 pulse one cycle after rise4", dn, dcyc, r4);
    end
    tick(); tick();
    checks++;
    if (edge_cnt !== 16'd4 || div_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL burst_hold got edge_cnt=%0d div_reset=%b done=%b busy=%b want 4 1 0 0", edge_cnt, div_reset, done, busy);
    end
  endtask

  task automatic test_free_run_stop();
    bit ok;
    configure(32'd2, 16'd0);
    rises = 0; done_seen = 0;
    do_start();
    wait_rises(20, 400, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL freerun_timeout got rises=%0d want 20", rises);
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (edge_cnt !== 16'd20 || busy !== 1'b0 || div_reset !== 1'b1 || done_seen !== 0) begin
      errors++; $display("FAIL freerun_stop got edge_cnt=%0d busy=%b div_reset=%b dones=%0d want 20 0 1 0", edge_cnt, busy, div_reset, done_seen);
    end
  endtask

  task automatic test_midrun_cfg();
    bit ok;
    bit prev_rise;
    bit changed = 1'b0;
    configure(32'd5, 16'd0);
    rises = 0;
    track_phase = 1'b1; had_edge = 1'b0; min_phase = 1000;
    do_start();
    wait_rises(1, 100, ok);
    tick(); tick();
    checks++;
    if (!ok || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL midrun_ready got first_rise=%b cfg_ready=%b want 1 1", ok, cfg_ready);
    end
    configure(32'd1, 16'd0);
    checks++;
    if (cfg_ready !== 1'b0 || div_period !== 32'd5) begin
      errors++; $display("FAIL midrun_pending got cfg_ready=%b div_period=%0d want 0 5", cfg_ready, div_period);
    end
    prev_rise = rise_seen;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (div_period !== 32'd5) begin changed = 1'b1; break; end
      prev_rise = rise_seen;
    end
    checks++;
    if (!changed || !prev_rise || div_period !== 32'd1) begin
      errors++; $display("FAIL midrun_apply got changed=%b after_rise=%b div_period=%0d want 1 1 1", changed, prev_rise, div_period);
    end
    tick();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL midrun_ready_back got %b want 1", cfg_ready);
    end
    for (int i = 0; i < 40; i++) tick();
    track_phase = 1'b0;
    checks++;
    if (min_phase < 2) begin
      errors++; $display("FAIL midrun_runt got min_phase=%0d want >=2", min_phase);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_clamp();
    configure(32'd7, 16'd0);
    checks++;
    if (div_period !== 32'd7) begin
      errors++; $display("FAIL clamp_set got %0d want 7", div_period);
    end
    configure(32'd0, 16'd0);
    checks++;
    if (div_period !== 32'd1) begin
      errors++; $display("FAIL clamp_zero got %0d want 1", div_period);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || div_reset !== 1'b1) begin
      errors++; $display("FAIL start_stop_idle got busy=%b div_reset=%b want 0 1", busy, div_reset);
    end
    configure(32'd2, 16'd3);
    rises = 0;
    do_start();
    wait_rises(3, 200, ok);
    done_seen = 0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (!ok || busy !== 1'b0 || div_reset !== 1'b1 || done_seen !== 0) begin
      errors++; $display("FAIL stop_final_rise got ok=%b busy=%b div_reset=%b dones=%0d want 1 0 1 0", ok, busy, div_reset, done_seen);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    configure(32'd2, 16'd10);
    rises = 0;
    do_start();
    wait_rises(3, 200, ok);
    tick();
    checks++;
    if (!ok || edge_cnt !== 16'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL async_pre got ok=%b edge_cnt=%0d busy=%b want 1 3 1", ok, edge_cnt, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || edge_cnt !== 16'd0 || div_reset !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset got busy=%b edge_cnt=%0d div_reset=%b done=%b want 0 0 1 0", busy, edge_cnt, div_reset, done);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_free_run_stop();
    test_midrun_cfg();
    test_clamp();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
